// File: rtl/fma_arb_pkg.sv
// Shared types for the fma_mul_arb multiplier arbiter: the operand bundle that is
// issued to the multiplier and the in-flight tag that tracks who owns each product.
package fma_arb_pkg;

    localparam int FMA_ARB_CMDW    = 32;
    // Tag ids are sized for the largest supported requester count (8).
    localparam int FMA_ARB_IDW_MAX = 3;

    typedef struct packed {
        logic [FMA_ARB_CMDW-1:0] command;
        logic [31:0]             in_1;
        logic [31:0]             in_2;
    } mul_req_t;

    typedef struct packed {
        logic                       valid;
        logic [FMA_ARB_IDW_MAX-1:0] id;
    } mul_tag_t;

endpackage

// File: rtl/fma_rr_pick.sv
// Combinational round-robin find-first: the first set bit of req at or after ptr,
// wrapping from NREQ-1 to 0, as a one-hot grant plus its index.
module fma_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);

    logic [IDW-1:0] pos;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        idx = '0;
        any = 1'b0;
        pos = '0;
        // Walk from the farthest offset down so the nearest request wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = IDW'((int'(ptr) + k) % NREQ);
            if (req[pos]) begin
                idx = pos;
                any = 1'b1;
            end
        end
    end

    assign gnt = any ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/fma_mul_arb.sv
// Round-robin arbiter sharing one pipelined multiplier between NREQ requesters.
// Optional `FMA_MUL_ARB_LOCK_EN adds req_lock: a locked winner keeps the pointer for bursts.
module fma_mul_arb
    import fma_arb_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int MAX_OUT = 4,
    parameter int IDW     = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
`ifdef FMA_MUL_ARB_LOCK_EN
    input  logic [NREQ-1:0]          req_lock,
`endif
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*32-1:0]       req_command,
    input  logic [NREQ*32-1:0]       req_in_1,
    input  logic [NREQ*32-1:0]       req_in_2,
    output logic                     mul_en,
    output logic [FMA_ARB_CMDW-1:0]  mul_command,
    output logic [31:0]              mul_in_1,
    output logic [31:0]              mul_in_2,
    input  logic [63:0]              mul_out,
    output logic                     rsp_valid,
    output logic [IDW-1:0]           rsp_id,
    output logic [63:0]              rsp_data,
    output logic                     busy
);

    localparam int CNTW = 4;

    logic [IDW-1:0]  ptr, start, win_idx, ptr_inc, issue_id;
    logic [NREQ-1:0] elig, gnt, rsp_hit;
    logic            win_any;
    logic [CNTW-1:0] cnt [NREQ];
    mul_tag_t        tags [MUL_LAT];
    mul_req_t        issue_q, win_req;

    always_comb begin
        elig    = '0;
        rsp_hit = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig[i]    = req_valid[i] && (cnt[i] < CNTW'(MAX_OUT));
            rsp_hit[i] = rsp_valid && (rsp_id == IDW'(i));
        end
    end

`ifdef FMA_MUL_ARB_LOCK_EN
    logic           lock_act;
    logic [IDW-1:0] alt_ptr;
    // While the lock owner cannot issue, the others rotate on their own pointer.
    assign start = (lock_act && !elig[ptr]) ? alt_ptr : ptr;
`else
    assign start = ptr;
`endif

    fma_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req (elig),
        .ptr (start),
        .gnt (gnt),
        .idx (win_idx),
        .any (win_any)
    );

    assign req_ready = reset ? '0 : gnt;
    assign ptr_inc   = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

    always_comb begin
        win_req.command = req_command[int'(win_idx)*32 +: 32];
        win_req.in_1    = req_in_1[int'(win_idx)*32 +: 32];
        win_req.in_2    = req_in_2[int'(win_idx)*32 +: 32];
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mul_en   <= 1'b0;
            issue_q  <= '0;
            issue_id <= '0;
            ptr      <= '0;
`ifdef FMA_MUL_ARB_LOCK_EN
            lock_act <= 1'b0;
            alt_ptr  <= '0;
`endif
        end else begin
            mul_en <= win_any;
            if (win_any) begin
                issue_q  <= win_req;
                issue_id <= win_idx;
`ifdef FMA_MUL_ARB_LOCK_EN
                if (lock_act && win_idx != ptr) begin
                    alt_ptr <= ptr_inc;
                end else if (req_lock[win_idx]) begin
                    lock_act <= 1'b1;
                    ptr      <= win_idx;
                    alt_ptr  <= ptr_inc;
                end else begin
                    lock_act <= 1'b0;
                    ptr      <= ptr_inc;
                end
`else
                ptr <= ptr_inc;
`endif
            end
        end
    end

    // NOTE: the tag array is reset entry by entry; only the valid bits matter, but a flop pipe this small costs nothing to clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < MUL_LAT; s++) tags[s] <= '0;
        end else begin
            tags[0] <= '{valid: mul_en, id: FMA_ARB_IDW_MAX'(issue_id)};
            for (int s = 1; s < MUL_LAT; s++) tags[s] <= tags[s-1];
        end
    end

    // A grant and a response for the same requester in one cycle cancel out.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (reset) begin
                cnt[i] <= '0;
            end else begin
                case ({gnt[i], rsp_hit[i]})
                    2'b10:   cnt[i] <= cnt[i] + CNTW'(1);
                    2'b01:   cnt[i] <= cnt[i] - CNTW'(1);
                    default: cnt[i] <= cnt[i];
                endcase
            end
        end
    end

    assign mul_command = issue_q.command;
    assign mul_in_1    = issue_q.in_1;
    assign mul_in_2    = issue_q.in_2;
    assign rsp_valid   = tags[MUL_LAT-1].valid;
    assign rsp_id      = tags[MUL_LAT-1].id[IDW-1:0];
    assign rsp_data    = mul_out;

    logic unused_tag_bits;
    assign unused_tag_bits = ^tags[MUL_LAT-1].id;

    always_comb begin
        busy = mul_en;
        for (int s = 0; s < MUL_LAT; s++) busy = busy | tags[s].valid;
    end

endmodule

// File: tb/tb_fma_mul_arb.sv
// Directed bench for fma_mul_arb with a two-stage model multiplier.
// MAX_OUT=3 lets a lone requester reach its cap while MUL_LAT=2.
module tb_fma_mul_arb;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int MAX_OUT = 3;
    localparam int IDW     = 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_command, req_in_1, req_in_2;
    logic              mul_en;
    logic [31:0]       mul_command, mul_in_1, mul_in_2;
    logic [63:0]       mul_out = '0;
    logic [63:0]       mul_p1 = '0;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [63:0]       rsp_data;
    logic              busy;
`ifdef FMA_MUL_ARB_LOCK_EN
    logic [NREQ-1:0]   req_lock = '0;
`endif

    int total = 0;
    int bad   = 0;

    logic [31:0] op1  [4] = '{32'd3, 32'd7, 32'd2, 32'd6};
    logic [31:0] op2  [4] = '{32'd5, 32'd11, 32'd9, 32'd6};
    logic [63:0] prod [4] = '{64'd15, 64'd77, 64'd18, 64'd36};

    logic [3:0] exp_g;
    logic       drained;
    logic [4:0] t2_rdy = 5'b10111;
    logic [4:0] t2_rsp = 5'b11000;
    logic [8:0] t3_v   = 9'b111101011;
    logic [8:0] t3_rdy = 9'b011101011;
    logic [8:0] t3_rsp = 9'b101011000;

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        mul_p1  <= mul_en ? ({32'd0, mul_in_1} * {32'd0, mul_in_2}) : 64'hbad0_bad0;
        mul_out <= mul_p1;
    end

    fma_mul_arb #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .MAX_OUT(MAX_OUT), .IDW(IDW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
`ifdef FMA_MUL_ARB_LOCK_EN
        .req_lock    (req_lock),
`endif
        .req_ready   (req_ready),
        .req_command (req_command),
        .req_in_1    (req_in_1),
        .req_in_2    (req_in_2),
        .mul_en      (mul_en),
        .mul_command (mul_command),
        .mul_in_1    (mul_in_1),
        .mul_in_2    (mul_in_2),
        .mul_out     (mul_out),
        .rsp_valid   (rsp_valid),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            req_command[i*32 +: 32] = 32'hA0 + 32'(i);
            req_in_1[i*32 +: 32]    = op1[i];
            req_in_2[i*32 +: 32]    = op2[i];
        end

        // Reset state, with every requester asking.
        reset     = 1'b1;
        req_valid = '1;
        tick();
        tick();
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_mul_en", mul_en, 0);
        check("rst_mul_in_1", mul_in_1, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_id", rsp_id, 0);
        check("rst_busy", busy, 0);
        tick();
        reset = 1'b0;

        // Test 1: all four requesters continuously valid.
        for (int c = 0; c < 8; c++) begin
            req_valid = '1;
            #1;
            exp_g = 4'(1 << (c % 4));
            check("t1_ready", req_ready, exp_g);
            check("t1_mul_en", mul_en, c >= 1);
            if (c == 1) begin
                check("t1_mul_cmd", mul_command, 32'hA0);
                check("t1_mul_in_1", mul_in_1, 3);
                check("t1_mul_in_2", mul_in_2, 5);
            end
            check("t1_rsp_valid", rsp_valid, c >= 3);
            if (c >= 3) begin
                check("t1_rsp_id", rsp_id, (c - 3) % 4);
                check("t1_rsp_data", rsp_data, prod[(c - 3) % 4]);
            end
            tick();
        end
        req_valid = '0;
        drained   = 1'b0;
        for (int k = 0; k < 12 && !drained; k++) begin
            #1;
            if (!busy) drained = 1'b1;
            else tick();
        end
        check("t1_drain", drained, 1);

        // Test 2: requester 2 alone hits MAX_OUT, then resumes after the first response.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = 4'b0100;
            #1;
            check("t2_ready", req_ready, t2_rdy[c] ? 4'b0100 : 4'b0000);
            check("t2_rsp_valid", rsp_valid, t2_rsp[c]);
            if (t2_rsp[c]) begin
                check("t2_rsp_id", rsp_id, 2);
                check("t2_rsp_data", rsp_data, 18);
            end
            tick();
        end

        // Test 3: grant and response on id 1 in the same cycle keep the count.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            req_valid = t3_v[c] ? 4'b0010 : 4'b0000;
            #1;
            check("t3_ready", req_ready, t3_rdy[c] ? 4'b0010 : 4'b0000);
            check("t3_rsp_valid", rsp_valid, t3_rsp[c]);
            if (t3_rsp[c]) check("t3_rsp_id", rsp_id, 1);
            tick();
        end

        // Test 4: reset one cycle after three issues drops everything in flight.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            req_valid = '1;
            #1;
            exp_g = 4'(1 << c);
            check("t4_ready", req_ready, exp_g);
            tick();
        end
        reset     = 1'b1;
        req_valid = '1;
        #1;
        check("t4_ready_in_reset", req_ready, 0);
        tick();
        reset     = 1'b0;
        req_valid = '0;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t4_no_rsp", rsp_valid, 0);
            check("t4_busy", busy, 0);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b0001;
            #1;
            check("t4_cnt_zeroed", req_ready, 4'b0001);
            tick();
        end

        // Test 5: pointer wraps from 3 back to 0.
        do_reset();
        req_valid = 4'b0100;
        #1;
        check("t5_ready_2", req_ready, 4'b0100);
        tick();
        for (int c = 0; c < 3; c++) begin
            req_valid = 4'b1001;
            #1;
            check("t5_wrap", req_ready, (c == 1) ? 4'b0001 : 4'b1000);
            tick();
        end

`ifdef FMA_MUL_ARB_LOCK_EN
        // Test 6: requester 1 locks priority; others rotate while it is capped.
        do_reset();
        req_lock = 4'b0010;
        for (int c = 0; c < 9; c++) begin
            req_valid = (c == 0) ? 4'b0010 : 4'b0111;
            #1;
            case (c)
                3:       exp_g = 4'b0100;
                7:       exp_g = 4'b0001;
                default: exp_g = 4'b0010;
            endcase
            check("t6_lock", req_ready, exp_g);
            tick();
        end
        req_lock = '0;
`endif

        req_valid = '0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
